// File: rtl/ccw_input_pkg.sv
// ============================================================================
// Module      : ccw_input_pkg
// Description : Shared definitions for the counter-clockwise ring input port:
//               per-VC FSM one-hot encodings, packet field positions and
//               destination encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccw_input_pkg;

    // Packet field positions
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int VC_BIT  = 63;

    // Per-VC buffer FSM, one-hot
    typedef enum logic [2:0] {
        ST_EMPTY = 3'b001,
        ST_HOLD  = 3'b010,
        ST_DRAIN = 3'b100
    } vc_state_e;

    // Routing decision carried with each buffered packet
    typedef enum logic {
        DEST_CCW = 1'b0,
        DEST_PE  = 1'b1
    } dest_e;

    // A packet whose hop count has reached zero is ejected to the local PE.
    function automatic dest_e route_of(input logic [HOP_MSB-HOP_LSB:0] hop);
        return (hop == '0) ? DEST_PE : DEST_CCW;
    endfunction

endpackage : ccw_input_pkg

`default_nettype wire

// File: rtl/ccw_input_vc.sv
// ============================================================================
// Module      : ccw_input_vc
// Description : Single virtual-channel slot of the ccw input port: one packet
//               buffer, its routing decision and the EMPTY/HOLD/DRAIN
//               request/grant FSM.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               we_i              - write strobe for this VC (polarity decoded)
//               data_i            - incoming packet
//               grant_ccw_i/pe_i  - grants from the ccw / pe output ports
//               empty_o           - slot can accept a packet
//               req_ccw_o/pe_o    - requests to the ccw / pe output ports
//               data_o            - buffered packet
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccw_input_vc
    import ccw_input_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  grant_ccw_i,
    input  logic                  grant_pe_i,
    output logic                  empty_o,
    output logic                  req_ccw_o,
    output logic                  req_pe_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    vc_state_e             state_q, state_d;
    dest_e                 dest_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic                  w_wr;
    logic                  w_grant;

    // A write to a non-empty slot is an upstream protocol error; drop it.
    assign w_wr    = we_i && (state_q == ST_EMPTY);
    // Only the grant of the chosen destination matters.
    assign w_grant = (dest_q == DEST_PE) ? grant_pe_i : grant_ccw_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            dest_q  <= DEST_CCW;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (w_wr) begin
                buf_q  <= data_i;
                dest_q <= route_of(data_i[HOP_MSB:HOP_LSB]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (w_wr)     state_d = ST_HOLD;
            ST_HOLD:  if (w_grant)  state_d = ST_DRAIN;
            ST_DRAIN: if (!w_grant) state_d = ST_EMPTY;
            default:                state_d = ST_EMPTY;
        endcase
    end

    assign empty_o   = (state_q == ST_EMPTY);
    assign req_ccw_o = (state_q == ST_HOLD) && (dest_q == DEST_CCW);
    assign req_pe_o  = (state_q == ST_HOLD) && (dest_q == DEST_PE);
    assign data_o    = buf_q;

endmodule : ccw_input_vc

`default_nettype wire

// File: rtl/ccw_input.sv
// ============================================================================
// Module      : ccw_input
// Description : Link-side receiver for the counter-clockwise ring channel.
//               Buffers one packet per VC (even/odd, selected by the global
//               cycle polarity) and requests either the local PE output port
//               (hop == 0) or this router's ccw output port.
//               Optional build macro CCW_INPUT_VCCHK_EN adds a sticky vc_err
//               output flagging packets whose bit 63 disagrees with the slot.
// Ports       : clk, rst, polarity        - clock, sync reset, cycle parity
//               ccwsi, ccwdi, ccwri       - upstream link strobe/data/ready
//               request_{ccw,pe}_{even,odd} - requests to output ports
//               grant_{ccw,pe}_{even,odd}   - grants from output ports
//               data_out_{even,odd}       - buffered packet per VC
//               vc_err                    - (CCW_INPUT_VCCHK_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccw_input
    import ccw_input_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  ccwsi,
    output logic                  ccwri,
    input  logic [DATA_WIDTH-1:0] ccwdi,
    output logic                  request_ccw_even,
    output logic                  request_ccw_odd,
    output logic                  request_pe_even,
    output logic                  request_pe_odd,
    input  logic                  grant_ccw_even,
    input  logic                  grant_ccw_odd,
    input  logic                  grant_pe_even,
    input  logic                  grant_pe_odd,
    output logic [DATA_WIDTH-1:0] data_out_even,
    output logic [DATA_WIDTH-1:0] data_out_odd
`ifdef CCW_INPUT_VCCHK_EN
    ,
    output logic                  vc_err
`endif
);

    logic w_we_even, w_we_odd;
    logic w_empty_even, w_empty_odd;

    // The upstream drives the even VC in polarity-1 cycles, odd in polarity-0.
    assign w_we_even = ccwsi &&  polarity;
    assign w_we_odd  = ccwsi && !polarity;

    // Ready advertises the VC the upstream may target next cycle.
    assign ccwri = polarity ? w_empty_odd : w_empty_even;

    ccw_input_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_even (
        .clk         (clk),
        .rst         (rst),
        .we_i        (w_we_even),
        .data_i      (ccwdi),
        .grant_ccw_i (grant_ccw_even),
        .grant_pe_i  (grant_pe_even),
        .empty_o     (w_empty_even),
        .req_ccw_o   (request_ccw_even),
        .req_pe_o    (request_pe_even),
        .data_o      (data_out_even)
    );

    ccw_input_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_odd (
        .clk         (clk),
        .rst         (rst),
        .we_i        (w_we_odd),
        .data_i      (ccwdi),
        .grant_ccw_i (grant_ccw_odd),
        .grant_pe_i  (grant_pe_odd),
        .empty_o     (w_empty_odd),
        .req_ccw_o   (request_ccw_odd),
        .req_pe_o    (request_pe_odd),
        .data_o      (data_out_odd)
    );

`ifdef CCW_INPUT_VCCHK_EN
    logic vc_err_q;
    logic w_vc_mismatch;

    // Only accepted writes are checked; a dropped write never lands in a slot.
    assign w_vc_mismatch = (w_we_even && w_empty_even &&  ccwdi[VC_BIT]) ||
                           (w_we_odd  && w_empty_odd  && !ccwdi[VC_BIT]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vc_err_q <= 1'b0;
        end else if (w_vc_mismatch) begin
            vc_err_q <= 1'b1;
        end
    end

    assign vc_err = vc_err_q;
`endif

endmodule : ccw_input

`default_nettype wire

// File: tb/tb_ccw_input.sv
// ============================================================================
// Module      : tb_ccw_input
// Description : Directed self-checking bench for ccw_input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccw_input;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          polarity;
    logic          ccwsi;
    logic          ccwri;
    logic [DW-1:0] ccwdi;
    logic          request_ccw_even, request_ccw_odd;
    logic          request_pe_even, request_pe_odd;
    logic          grant_ccw_even, grant_ccw_odd;
    logic          grant_pe_even, grant_pe_odd;
    logic [DW-1:0] data_out_even, data_out_odd;
`ifdef CCW_INPUT_VCCHK_EN
    logic          vc_err;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [DW-1:0] PKT_A = 64'h000F_0000_0000_0001; // hop 0x0F -> CCW
    localparam logic [DW-1:0] PKT_B = 64'h8000_0000_0000_00B0; // hop 0x00 -> PE
    localparam logic [DW-1:0] PKT_X = 64'h0000_0000_0000_DEAD;

    always #5 clk = ~clk;

    ccw_input #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .polarity         (polarity),
        .ccwsi            (ccwsi),
        .ccwri            (ccwri),
        .ccwdi            (ccwdi),
        .request_ccw_even (request_ccw_even),
        .request_ccw_odd  (request_ccw_odd),
        .request_pe_even  (request_pe_even),
        .request_pe_odd   (request_pe_odd),
        .grant_ccw_even   (grant_ccw_even),
        .grant_ccw_odd    (grant_ccw_odd),
        .grant_pe_even    (grant_pe_even),
        .grant_pe_odd     (grant_pe_odd),
        .data_out_even    (data_out_even),
        .data_out_odd     (data_out_odd)
`ifdef CCW_INPUT_VCCHK_EN
        ,
        .vc_err           (vc_err)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: let the edge happen, then advance polarity for the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        polarity = ~polarity;
        #1;
    endtask

    initial begin
        rst = 1'b1; polarity = 1'b0; ccwsi = 1'b0; ccwdi = '0;
        grant_ccw_even = 1'b0; grant_ccw_odd = 1'b0;
        grant_pe_even  = 1'b0; grant_pe_odd  = 1'b0;
        tick(); tick();

        // Reset state (polarity now 0 -> ccwri shows even slot)
        chk("rst_ccwri",    {63'd0, ccwri}, 64'd1);
        chk("rst_req_ccwe", {63'd0, request_ccw_even}, 64'd0);
        chk("rst_req_pee",  {63'd0, request_pe_even}, 64'd0);
        chk("rst_req_ccwo", {63'd0, request_ccw_odd}, 64'd0);
        chk("rst_req_peo",  {63'd0, request_pe_odd}, 64'd0);
        chk("rst_dout_e",   data_out_even, 64'd0);
        chk("rst_dout_o",   data_out_odd, 64'd0);
`ifdef CCW_INPUT_VCCHK_EN
        chk("rst_vc_err",   {63'd0, vc_err}, 64'd0);
`endif
        rst = 1'b0;

        // Even write at a polarity-1 edge, hop 0x0F -> CCW
        tick();                                   // polarity -> 1
        ccwsi = 1'b1; ccwdi = PKT_A;
        tick();                                   // polarity -> 0
        ccwsi = 1'b0; ccwdi = '0;
        chk("even_ccwri_busy", {63'd0, ccwri}, 64'd0);
        chk("even_req_ccw",    {63'd0, request_ccw_even}, 64'd1);
        chk("even_req_pe",     {63'd0, request_pe_even}, 64'd0);
        chk("even_dout",       data_out_even, PKT_A);

        // Odd write at a polarity-0 edge, hop 0x00 -> PE, while even holds
        ccwsi = 1'b1; ccwdi = PKT_B;
        tick();                                   // polarity -> 1
        ccwsi = 1'b0; ccwdi = '0;
        chk("odd_ccwri_busy",  {63'd0, ccwri}, 64'd0);
        chk("odd_req_pe",      {63'd0, request_pe_odd}, 64'd1);
        chk("odd_req_ccw",     {63'd0, request_ccw_odd}, 64'd0);
        chk("both_req_even",   {63'd0, request_ccw_even}, 64'd1);
        chk("odd_dout",        data_out_odd, PKT_B);
        chk("even_dout_keep",  data_out_even, PKT_A);

        // Grant of the non-selected destination is ignored
        grant_pe_even = 1'b1;
        tick();                                   // polarity -> 0
        grant_pe_even = 1'b0;
        chk("wrong_grant_req", {63'd0, request_ccw_even}, 64'd1);

        // Write to full even slot is dropped
        tick();                                   // polarity -> 1
        ccwsi = 1'b1; ccwdi = PKT_X;
        tick();                                   // polarity -> 0
        ccwsi = 1'b0; ccwdi = '0;
        chk("full_wr_dout",    data_out_even, PKT_A);
        chk("full_wr_req",     {63'd0, request_ccw_even}, 64'd1);
        chk("full_wr_ccwri",   {63'd0, ccwri}, 64'd0);

        // Odd drain: grant high two edges, then low
        grant_pe_odd = 1'b1;
        tick();                                   // polarity -> 1
        chk("odd_grant_req",   {63'd0, request_pe_odd}, 64'd0);
        chk("odd_drain_ccwri", {63'd0, ccwri}, 64'd0);
        tick();                                   // polarity -> 0, still DRAIN
        grant_pe_odd = 1'b0;
        tick();                                   // polarity -> 1, grant-low edge done
        chk("odd_empty_ccwri", {63'd0, ccwri}, 64'd1);
        chk("odd_dout_retain", data_out_odd, PKT_B);

        // Even grant, then reset while in DRAIN
        grant_ccw_even = 1'b1;
        tick();                                   // polarity -> 0
        chk("even_grant_req",  {63'd0, request_ccw_even}, 64'd0);
        chk("even_drain_ccwri",{63'd0, ccwri}, 64'd0);
        rst = 1'b1;
        tick();                                   // polarity -> 1
        rst = 1'b0; grant_ccw_even = 1'b0;
        chk("mid_rst_ccwri_o", {63'd0, ccwri}, 64'd1);
        chk("mid_rst_req",     {60'd0, request_ccw_even, request_pe_even,
                                       request_ccw_odd, request_pe_odd}, 64'd0);
        chk("mid_rst_dout_e",  data_out_even, 64'd0);
        chk("mid_rst_dout_o",  data_out_odd, 64'd0);
        tick();                                   // polarity -> 0
        chk("mid_rst_ccwri_e", {63'd0, ccwri}, 64'd1);

`ifdef CCW_INPUT_VCCHK_EN
        // Even write carrying bit63=1 is accepted but flags vc_err
        tick();                                   // polarity -> 1
        ccwsi = 1'b1; ccwdi = PKT_B;
        tick();
        ccwsi = 1'b0; ccwdi = '0;
        chk("vcchk_set",       {63'd0, vc_err}, 64'd1);
        chk("vcchk_req_pe_e",  {63'd0, request_pe_even}, 64'd1);
        tick(); tick();
        chk("vcchk_sticky",    {63'd0, vc_err}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("vcchk_clear",     {63'd0, vc_err}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ccw_input

`default_nettype wire
